// File: rtl/load_align_unit_pkg.sv
// Shared constants for the MIPS memory-stage load unit: load opcodes, FSM
// state encoding and the alignment/legality check.
package load_align_unit_pkg;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // True when the load can never reach memory: unknown opcode or an address
  // that is not naturally aligned for its access size.
  function automatic logic load_fault(input logic [2:0] op, input logic [1:0] lsb);
    logic fault;
    case (op)
      OP_LB, OP_LBU: fault = 1'b0;
      OP_LH, OP_LHU: fault = lsb[0];
      OP_LW:         fault = (lsb != 2'b00);
      default:       fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/signext.sv
// Extends a narrow lane to 32 bits, replicating the lane MSB when f is set
// and zero-filling otherwise.
module signext #(
  parameter int width = 8
) (
  input  logic [width-1:0] a,
  input  logic             f,
  output logic [31:0]      y
);

  assign y = {{(32 - width){f & a[width-1]}}, a};

endmodule

// File: rtl/load_align_unit.sv
// Memory-stage load unit: issues one word-aligned read per load, picks the
// addressed lane, extends it and hands the result to writeback.
module load_align_unit
  import load_align_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_op,
  input  logic [RD_W-1:0]   req_rd,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic [RD_W-1:0]   resp_rd,
  output logic              resp_err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        op_q;
  logic [RD_W-1:0]   rd_q;
  logic [31:0]       resp_data_q;
  logic              resp_err_q;
  logic              req_fault;

  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [31:0]       byte_ext;
  logic [31:0]       half_ext;
  logic [31:0]       load_result;

  assign req_fault = load_fault(req_op, req_addr[1:0]);

  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_lane = mem_rdata[7:0];
      2'd1:    byte_lane = mem_rdata[15:8];
      2'd2:    byte_lane = mem_rdata[23:16];
      default: byte_lane = mem_rdata[31:24];
    endcase
    half_lane = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  signext #(.width(8)) u_sext_byte (
    .a (byte_lane),
    .f (~op_q[2]),
    .y (byte_ext)
  );

  signext #(.width(16)) u_sext_half (
    .a (half_lane),
    .f (~op_q[2]),
    .y (half_ext)
  );

  always_comb begin
    case (op_q)
      OP_LB, OP_LBU: load_result = byte_ext;
      OP_LH, OP_LHU: load_result = half_ext;
      default:       load_result = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid) state_d = req_fault ? S_RESP : S_WAIT;
      S_WAIT: if (mem_ack) state_d = S_RESP;
      S_RESP: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            op_q   <= req_op;
            rd_q   <= req_rd;
            if (req_fault) begin
              resp_data_q <= '0;
              resp_err_q  <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            resp_data_q <= load_result;
            resp_err_q  <= 1'b0;
          end
        end
        S_RESP: begin
          if (resp_ready) resp_err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // req_ready is gated by resetn so it stays low while reset is asserted.
  always_comb begin
    req_ready  = (state_q == S_IDLE) && resetn;
    mem_req    = (state_q == S_WAIT);
    mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    resp_valid = (state_q == S_RESP);
    resp_data  = resp_data_q;
    resp_rd    = rd_q;
    resp_err   = resp_err_q;
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed self-checking bench for load_align_unit: lane select, extension,
// fault responses, stalls, backpressure and mid-operation reset.
module tb_load_align_unit;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_op;
  logic [4:0]  req_rd;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;

  int vectors;
  int miscompares;

  load_align_unit #(.ADDR_W(32), .RD_W(5)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_op     (req_op),
    .req_rd     (req_rd),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_rd    (resp_rd),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_op = '0; req_rd = '0;
    mem_ack = 1'b0; mem_rdata = '0; resp_ready = 1'b0;
    #12;
    vectors++;
    if ({req_ready, mem_req, resp_valid, resp_err} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %b want 0000", {req_ready, mem_req, resp_valid, resp_err});
    end
    vectors++;
    if ({mem_addr, resp_data, resp_rd} !== 69'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: addr %h data %h rd %h want 0", mem_addr, resp_data, resp_rd);
    end
    resetn = 1'b1;
    step();
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_ready: got %b want 1", req_ready);
    end
  endtask

  // Legal byte and halfword loads, all acked in the first WAIT cycle.
  task automatic test_lane_loads();
    logic [2:0]  ops  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001};
    logic [31:0] addrs[5] = '{32'h1003, 32'h1003, 32'h1002, 32'h1002, 32'h1000};
    logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h00001234};
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_addr = addrs[i]; req_op = ops[i]; req_rd = 5'(i + 3);
      vectors++;
      if (req_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL lane%0d_ready: got %b want 1", i, req_ready);
      end
      step();
      req_valid = 1'b0;
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h1000 || resp_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL lane%0d_issue: req %b addr %h rv %b want 1 00001000 0", i, mem_req, mem_addr, resp_valid);
      end
      mem_ack = 1'b1; mem_rdata = 32'h80FF1234;
      step();
      mem_ack = 1'b0; mem_rdata = 32'h0;
      vectors++;
      if (resp_valid !== 1'b1 || resp_data !== exps[i] || resp_err !== 1'b0 || resp_rd !== 5'(i + 3)) begin
        miscompares++;
        $display("[TB] FAIL lane%0d_resp: valid %b data %h err %b rd %0d want 1 %h 0 %0d",
                 i, resp_valid, resp_data, resp_err, resp_rd, exps[i], i + 3);
      end
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      vectors++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL lane%0d_done: valid %b ready %b want 0 1", i, resp_valid, req_ready);
      end
    end
  endtask

  // Misaligned and illegal requests answer next cycle without touching memory.
  task automatic test_faults();
    logic [2:0]  ops  [5] = '{3'b010, 3'b011, 3'b001, 3'b101, 3'b110};
    logic [31:0] addrs[5] = '{32'h1002, 32'h1000, 32'h1001, 32'h1003, 32'h1000};
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_addr = addrs[i]; req_op = ops[i]; req_rd = 5'(20 + i);
      step();
      req_valid = 1'b0;
      vectors++;
      if (mem_req !== 1'b0 || resp_valid !== 1'b1 || resp_err !== 1'b1 ||
          resp_data !== 32'h0 || resp_rd !== 5'(20 + i)) begin
        miscompares++;
        $display("[TB] FAIL fault%0d_resp: req %b valid %b err %b data %h rd %0d want 0 1 1 0 %0d",
                 i, mem_req, resp_valid, resp_err, resp_data, resp_rd, 20 + i);
      end
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      vectors++;
      if (resp_valid !== 1'b0 || resp_err !== 1'b0 || mem_req !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL fault%0d_clear: valid %b err %b req %b want 0 0 0", i, resp_valid, resp_err, mem_req);
      end
    end
  endtask

  task automatic test_stall_backpressure();
    req_valid = 1'b1; req_addr = 32'h2000; req_op = 3'b010; req_rd = 5'd9;
    step();
    req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      mem_rdata = 32'h1111_0000 + 32'(c);
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h2000 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stall%0d: req %b addr %h ready %b valid %b want 1 00002000 0 0",
                 c, mem_req, mem_addr, req_ready, resp_valid);
      end
      step();
    end
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h5555AAAA;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (resp_valid !== 1'b1 || resp_data !== 32'hDEADBEEF || req_ready !== 1'b0 ||
          mem_req !== 1'b0 || resp_rd !== 5'd9) begin
        miscompares++;
        $display("[TB] FAIL hold%0d: valid %b data %h ready %b req %b rd %0d want 1 deadbeef 0 0 9",
                 c, resp_valid, resp_data, req_ready, mem_req, resp_rd);
      end
      step();
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    vectors++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stall_done: valid %b ready %b want 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    req_valid = 1'b1; req_addr = 32'h3005; req_op = 3'b000; req_rd = 5'd17;
    step();
    req_valid = 1'b0;
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midrst_wait: req %b want 1", mem_req);
    end
    resetn = 1'b0;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrst_async: req %b valid %b ready %b want 0 0 0", mem_req, resp_valid, req_ready);
    end
    step();
    step();
    resetn = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    step();
    mem_ack = 1'b0;
    vectors++;
    if (resp_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midrst_late_ack: valid %b req %b ready %b want 0 0 1", resp_valid, mem_req, req_ready);
    end
    req_valid = 1'b1; req_addr = 32'h1001; req_op = 3'b000; req_rd = 5'd4;
    step();
    req_valid = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h0000A500;
    step();
    mem_ack = 1'b0;
    vectors++;
    if (resp_valid !== 1'b1 || resp_data !== 32'hFFFFFFA5 || resp_err !== 1'b0 || resp_rd !== 5'd4) begin
      miscompares++;
      $display("[TB] FAIL midrst_next_lb: valid %b data %h err %b rd %0d want 1 ffffffa5 0 4",
               resp_valid, resp_data, resp_err, resp_rd);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_lane_loads();
    test_faults();
    test_stall_backpressure();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
